// File: rtl/if_id_hazard_latch.sv
// IF/ID pipeline register for the DLX pipeline: latches pre-decoded fetch fields,
// detects load-use hazards against the instruction in EX, and kills wrong-path work on Flush.
module if_id_hazard_latch #(
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:5]            OpCode,
    input  logic [0:5]            Function,
    input  logic [0:4]            Rs1,
    input  logic [0:4]            Rs2,
    input  logic [0:4]            Rd,
    input  logic [0:15]           Immediate,
    input  logic [0:31]           PCPlusFour,
    input  logic                  Flush,
    input  logic                  Hold,
    output logic [0:5]            IdOpCode,
    output logic [0:5]            IdFunction,
    output logic [0:4]            IdRs1,
    output logic [0:4]            IdRs2,
    output logic [0:4]            IdRd,
    output logic [0:15]           IdImmediate,
    output logic [0:31]           IdPCPlusFour,
    output logic                  IdValid,
    output logic                  IssueValid,
    output logic                  Stall,
    output logic [0:CountWidth-1] StallCount
);

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] pc;
    } id_fields_t;

    localparam logic [CountWidth-1:0] CntOne = {{(CountWidth-1){1'b0}}, 1'b1};
    localparam logic [CountWidth-1:0] CntMax = {CountWidth{1'b1}};

    id_fields_t            id_q, id_d;
    logic                  id_valid_q, id_valid_d;
    logic                  ex_is_load_q, ex_is_load_d;
    logic [4:0]            ex_rd_q, ex_rd_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic                  load_use;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic rs1_is_src(input logic [5:0] op);
        case (op)
            6'h02, 6'h03, 6'h0F, 6'h10, 6'h11, 6'h15: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic rs2_is_src(input logic [5:0] op);
        case (op)
            6'h00, 6'h01, 6'h28, 6'h29, 6'h2B, 6'h2E, 6'h2F: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Hazard looks only at registered state so it cannot form a loop through fetch.
    always_comb begin
        load_use = id_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
                   (((ex_rd_q == id_q.rs1) && rs1_is_src(id_q.op)) ||
                    ((ex_rd_q == id_q.rs2) && rs2_is_src(id_q.op)));
    end

    always_comb begin
        id_d         = id_q;
        id_valid_d   = id_valid_q;
        ex_is_load_d = ex_is_load_q;
        ex_rd_d      = ex_rd_q;
        cnt_d        = cnt_q;
        if (Flush) begin
            id_d         = '0;
            id_valid_d   = 1'b0;
            ex_is_load_d = 1'b0;
        end else if (Hold) begin
            id_d = id_q;
        end else if (load_use) begin
            ex_is_load_d = 1'b0;
            if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
        end else begin
            id_d         = '{op: OpCode, fn: Function, rs1: Rs1, rs2: Rs2, rd: Rd,
                             imm: Immediate, pc: PCPlusFour};
            id_valid_d   = 1'b1;
            ex_is_load_d = id_valid_q && is_load(id_q.op);
            ex_rd_d      = id_q.rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q         <= '0;
            id_valid_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_rd_q      <= '0;
            cnt_q        <= '0;
        end else begin
            id_q         <= id_d;
            id_valid_q   <= id_valid_d;
            ex_is_load_q <= ex_is_load_d;
            ex_rd_q      <= ex_rd_d;
            cnt_q        <= cnt_d;
        end
    end

    assign IdOpCode     = id_q.op;
    assign IdFunction   = id_q.fn;
    assign IdRs1        = id_q.rs1;
    assign IdRs2        = id_q.rs2;
    assign IdRd         = id_q.rd;
    assign IdImmediate  = id_q.imm;
    assign IdPCPlusFour = id_q.pc;
    assign IdValid      = id_valid_q;
    assign Stall        = (load_use || Hold) && !Flush;
    assign IssueValid   = id_valid_q && !load_use && !Hold && !Flush;
    assign StallCount   = cnt_q;

endmodule

// File: tb/tb_if_id_hazard_latch.sv
// Randomized and directed bench for if_id_hazard_latch against a behavioural pipeline model.
module tb_if_id_hazard_latch;

    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [0:5]    OpCode, Function;
    logic [0:4]    Rs1, Rs2, Rd;
    logic [0:15]   Immediate;
    logic [0:31]   PCPlusFour;
    logic          Flush, Hold;
    logic [0:5]    IdOpCode, IdFunction;
    logic [0:4]    IdRs1, IdRs2, IdRd;
    logic [0:15]   IdImmediate;
    logic [0:31]   IdPCPlusFour;
    logic          IdValid, IssueValid, Stall;
    logic [0:CW-1] StallCount;

    if_id_hazard_latch #(.CountWidth(CW)) dut (
        .clk(clk), .reset(reset),
        .OpCode(OpCode), .Function(Function), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .Immediate(Immediate), .PCPlusFour(PCPlusFour), .Flush(Flush), .Hold(Hold),
        .IdOpCode(IdOpCode), .IdFunction(IdFunction), .IdRs1(IdRs1), .IdRs2(IdRs2),
        .IdRd(IdRd), .IdImmediate(IdImmediate), .IdPCPlusFour(IdPCPlusFour),
        .IdValid(IdValid), .IssueValid(IssueValid), .Stall(Stall), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference pipeline state, kept as plain integers.
    int m_valid, m_op, m_fn, m_rs1, m_rs2, m_rd, m_imm;
    int unsigned m_pc;
    int m_exload, m_exrd, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit op_is_load(int op);
        return op inside {'h20, 'h21, 'h23, 'h24, 'h25, 'h26, 'h27};
    endfunction

    function automatic bit op_reads_rs1(int op);
        return !(op inside {'h02, 'h03, 'h0F, 'h10, 'h11, 'h15});
    endfunction

    function automatic bit op_reads_rs2(int op);
        return op inside {'h00, 'h01, 'h28, 'h29, 'h2B, 'h2E, 'h2F};
    endfunction

    function automatic bit m_hazard();
        if (m_valid == 0 || m_exload == 0 || m_exrd == 0) return 1'b0;
        return (m_exrd == m_rs1 && op_reads_rs1(m_op)) || (m_exrd == m_rs2 && op_reads_rs2(m_op));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_fn = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0; m_pc = 0;
        m_exload = 0; m_exrd = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        if (reset) model_reset();
        else if (Flush) begin
            m_valid = 0; m_op = 0; m_fn = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0; m_pc = 0;
            m_exload = 0;
        end else if (Hold) begin
        end else if (m_hazard()) begin
            m_exload = 0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_exload = (m_valid != 0) && op_is_load(m_op);
            m_exrd   = m_rd;
            m_valid = 1; m_op = int'(OpCode); m_fn = int'(Function); m_rs1 = int'(Rs1);
            m_rs2 = int'(Rs2); m_rd = int'(Rd); m_imm = int'(Immediate); m_pc = PCPlusFour;
        end
    endtask

    task automatic compare_all();
        bit hz;
        hz = m_hazard();
        check("IdOpCode",     32'(IdOpCode),     32'(m_op));
        check("IdFunction",   32'(IdFunction),   32'(m_fn));
        check("IdRs1",        32'(IdRs1),        32'(m_rs1));
        check("IdRs2",        32'(IdRs2),        32'(m_rs2));
        check("IdRd",         32'(IdRd),         32'(m_rd));
        check("IdImmediate",  32'(IdImmediate),  32'(m_imm));
        check("IdPCPlusFour", IdPCPlusFour,      m_pc);
        check("IdValid",      32'(IdValid),      32'(m_valid));
        check("Stall",        32'(Stall),        32'((hz || Hold) && !Flush));
        check("IssueValid",   32'(IssueValid),   32'(m_valid != 0 && !hz && !Hold && !Flush));
        check("StallCount",   32'(StallCount),   32'(m_cnt));
    endtask

    task automatic drive(input int op, input int rs1, input int rs2, input int rd,
                         input bit fl, input bit hd);
        OpCode     = 6'(op);
        Function   = 6'($urandom);
        Rs1        = 5'(rs1);
        Rs2        = 5'(rs2);
        Rd         = 5'(rd);
        Immediate  = 16'($urandom);
        PCPlusFour = $urandom;
        Flush      = fl;
        Hold       = hd;
    endtask

    task automatic tick();
        #1 compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        repeat (2) begin drive('h15, 0, 0, 0, 0, 0); tick(); end
    endtask

    int cnt_saved;
    int ops[$] = '{'h00, 'h01, 'h08, 'h23, 'h20, 'h2B, 'h02, 'h0F, 'h15, 'h04, 'h26};

    initial begin
        reset = 1'b1;
        drive('h00, 0, 0, 0, 0, 0);
        model_reset();
        #1 compare_all();
        @(posedge clk); model_edge(); #1;
        reset = 1'b0;

        // First instruction after reset
        drive('h08, 1, 0, 2, 0, 0); tick();
        check("first_valid", 32'(IdValid), 32'd1);
        check("first_rd", 32'(IdRd), 32'd2);
        #1 check("first_issue", 32'(IssueValid), 32'd1);

        // Load-use: LW r3 then ADD r?,r3
        settle();
        drive('h23, 1, 0, 3, 0, 0); tick();
        drive('h00, 3, 5, 4, 0, 0); tick();
        drive('h08, 1, 0, 5, 0, 0);
        #1 check("lu_stall", 32'(Stall), 32'd1);
        check("lu_issue", 32'(IssueValid), 32'd0);
        tick();
        check("lu_held_op", 32'(IdOpCode), 32'h00);
        check("lu_count", 32'(StallCount), 32'd1);
        #1 check("lu_stall_drop", 32'(Stall), 32'd0);
        check("lu_issue_next", 32'(IssueValid), 32'd1);
        tick();
        check("lu_advance", 32'(IdOpCode), 32'h08);

        // No-hazard cases
        settle();
        drive('h23, 1, 0, 0, 0, 0); tick();
        drive('h00, 0, 0, 4, 0, 0); tick();
        drive('h15, 0, 0, 0, 0, 0);
        #1 check("nohz_r0", 32'(Stall), 32'd0);
        settle();
        drive('h23, 1, 0, 3, 0, 0); tick();
        drive('h02, 3, 0, 0, 0, 0); tick();
        drive('h15, 0, 0, 0, 0, 0);
        #1 check("nohz_j", 32'(Stall), 32'd0);
        settle();
        drive('h23, 1, 0, 3, 0, 0); tick();
        drive('h08, 1, 3, 6, 0, 0); tick();
        drive('h15, 0, 0, 0, 0, 0);
        #1 check("nohz_addi_rs2", 32'(Stall), 32'd0);

        // Flush of a valid instruction, then flush during load-use
        settle();
        drive('h08, 1, 0, 2, 0, 0); tick();
        drive('h08, 1, 0, 2, 1, 0); tick();
        check("flush_valid", 32'(IdValid), 32'd0);
        settle();
        drive('h23, 1, 0, 3, 0, 0); tick();
        drive('h00, 3, 0, 4, 0, 0); tick();
        cnt_saved = int'(StallCount);
        drive('h15, 0, 0, 0, 1, 0);
        #1 check("flush_lu_stall", 32'(Stall), 32'd0);
        tick();
        check("flush_lu_valid", 32'(IdValid), 32'd0);
        check("flush_lu_count", 32'(StallCount), 32'(cnt_saved));

        // Hold for three cycles mid-stream
        settle();
        drive('h08, 1, 0, 6, 0, 0); tick();
        repeat (3) begin
            drive('h23, 2, 0, 7, 0, 1);
            #1 check("hold_stall", 32'(Stall), 32'd1);
            tick();
            check("hold_rd", 32'(IdRd), 32'd6);
        end
        drive('h23, 2, 0, 7, 0, 0); tick();
        check("hold_release", 32'(IdRd), 32'd7);

        // Saturation: five separate load-use stalls
        repeat (5) begin
            settle();
            drive('h23, 1, 0, 3, 0, 0); tick();
            drive('h00, 3, 0, 4, 0, 0); tick();
            drive('h15, 0, 0, 0, 0, 0); tick(); tick();
        end
        check("sat_count", 32'(StallCount), 32'(CNT_MAX));

        // Random traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 400; i++) begin
            drive(ops[$urandom_range(ops.size() - 1)], $urandom_range(3), $urandom_range(3),
                  $urandom_range(3), $urandom_range(99) < 8, $urandom_range(99) < 15);
            tick();
            if (i == 200) begin
                #2 reset = 1'b1;
                #1 model_reset();
                check("async_rst_valid", 32'(IdValid), 32'd0);
                check("async_rst_count", 32'(StallCount), 32'd0);
                compare_all();
                #1 reset = 1'b0;
                @(posedge clk); model_edge(); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_hazard_latch.md
# if_id_hazard_latch

IF/ID pipeline register with load-use hazard detection and branch flush for the DLX pipelined processor. Sits directly downstream of the instruction fetch stage. It latches the fetch stage's pre-decoded fields (OpCode, Function, Rs1, Rs2, Rd, Immediate, PCPlusFour) and presents them to decode/execute. It tracks the instruction most recently issued to EX, freezes fetch and issues a bubble on a load-use dependence, and discards wrong-path instructions on Flush.

## Interface
- CountWidth, 16, width of the saturating hazard-stall counter

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- OpCode  in  [0:5]  opcode from fetch
- Function  in  [0:5]  R-type function from fetch
- Rs1, Rs2, Rd  in  [0:4] each  register fields from fetch; Rd is the destination for both R- and I-type
- Immediate  in  [0:15]  immediate from fetch
- PCPlusFour  in  [0:31]  PC+4 from fetch
- Flush  in  1  taken branch/jump resolved; kill the instruction in ID
- Hold  in  1  global pipeline freeze (memory wait)
- IdOpCode, IdFunction  out  [0:5]  latched fields
- IdRs1, IdRs2, IdRd  out  [0:4]  latched fields
- IdImmediate  out  [0:15]  latched field
- IdPCPlusFour  out  [0:31]  latched field
- IdValid  out  1  ID register holds a real instruction
- IssueValid  out  1  ID instruction advances to EX this cycle
- Stall  out  1  fetch must hold PC and not advance
- StallCount  out  [0:CountWidth-1]  saturating count of load-use stall cycles

## Operation
- Load opcodes: 0x20, 0x21, 0x23, 0x24, 0x25, 0x26, 0x27.
- Rs1 is a source unless the opcode is one of 0x02 J, 0x03 JAL, 0x0F LHI, 0x10 RFE, 0x11 TRAP, 0x15 NOP.
- Rs2 is a source for opcodes 0x00 and 0x01 (R-type) and for stores 0x28, 0x29, 0x2B, 0x2E, 0x2F.
- EX tracker registers: ExIsLoad (1 bit), ExRd (5 bits).
- LoadUse is combinational from registered state only. It is asserted when all of these hold:
  - IdValid = 1, ExIsLoad = 1, ExRd != 0;
  - ExRd == IdRs1 with Rs1 a source, or ExRd == IdRs2 with Rs2 a source.
- Stall = LoadUse | Hold. It is forced to 0 when Flush = 1.
- IssueValid = IdValid & !LoadUse & !Hold & !Flush.
- Per-edge update, highest priority first:
  - reset: all Id* fields, IdValid, ExIsLoad, ExRd and StallCount are 0.
  - Flush: Id* fields and IdValid are 0; ExIsLoad is 0; StallCount is held.
  - Hold: all state is held, including the EX tracker and the counter.
  - LoadUse: ID contents are held; ExIsLoad is 0 (bubble into EX); StallCount increments and saturates at all-ones.
  - Normal: ID is loaded from the inputs and IdValid becomes 1. ExIsLoad becomes IdValid & (IdOpCode is a load); ExRd becomes IdRd.
- A bubble (IdValid = 0) never creates a hazard and never loads ExIsLoad = 1.
- Flush while LoadUse is active: Flush wins; the stalled instruction is discarded and no stall cycle is counted.

## Timing
- Latency: a fetch output appears on the Id* outputs one clock after the edge at which it is presented, provided Stall = 0.
- A load-use hazard costs exactly one stall cycle. After the bubble edge ExIsLoad = 0, so LoadUse drops and the dependent instruction issues on the next cycle.
- Back-to-back loads with a dependence each cost one cycle.
- reset is asynchronous: outputs go to 0 immediately, with no clock needed. Deasserting reset mid-stream resumes normal loading on the next edge.
- All outputs are 0 after reset, including Stall and IssueValid.

## Test plan
- Reset: assert reset between edges -> all outputs 0 immediately. Release, then present OpCode = 0x08, Rs1 = 1, Rd = 2 -> one edge later IdValid = 1, IdRd = 2, IssueValid = 1.
- Load-use hazard: LW r3 (OpCode = 0x23, Rd = 3) followed by ADD (OpCode = 0x00, Rs1 = 3) ->
  - Stall = 1 and IssueValid = 0 for exactly one cycle;
  - the ADD stays in ID; StallCount = 1;
  - the ADD issues the next cycle.
- No-hazard cases:
  - LW r0 followed by a reader of r0 -> no stall.
  - LW r3 followed by J (0x02) with Rs1 = 3 -> no stall.
  - LW r3 followed by ADDI (0x08) with Rs2 = 3 -> no stall.
- Flush: pulse Flush with a valid instruction in ID -> next edge IdValid = 0. Pulse Flush during an active LoadUse -> instruction dropped, Stall = 0, StallCount unchanged.
- Hold: hold for 3 cycles mid-stream -> Id* outputs, the EX tracker and StallCount are frozen, and Stall = 1. Release -> the sequence continues with no instruction lost or duplicated.
- Saturation (CountWidth = 2): 5 separate load-use stalls -> StallCount reaches 3 and stays at 3.
